// File: rtl/fir_sched_pkg.sv
// Shared types and sizing for the polyphase FIR scheduler.
package fir_sched_pkg;
    typedef enum logic {FILL, RUN} state_t;

    localparam int PHASES = 6;
    localparam int TAPS   = 4;
    localparam int HIST   = 3;

    typedef logic [2:0] phase_t;
endpackage

// File: rtl/fir_out_fifo.sv
// Two-entry synchronous FIFO holding MAC results tagged with their phase.
module fir_out_fifo #(
    parameter int DW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);
    logic [1:0][DW-1:0] mem;
    logic               wr_ptr, rd_ptr;
    logic               do_push, do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A full FIFO still accepts a push when it is draining in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign dout  = mem[rd_ptr];
endmodule

// File: rtl/fir_phase_sched.sv
// Time-shares one external 4-tap MAC across the six phases of a frame and
// returns the results in order through a small output buffer.
module fir_phase_sched
    import fir_sched_pkg::*;
#(
    parameter int W_IN  = 7,
    parameter int C_IN  = 5,
    parameter int Y_OUT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_IN-1:0]  s_data,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [C_IN-1:0]  cfg_data,
    output logic [W_IN-1:0]  mac_x0,
    output logic [W_IN-1:0]  mac_x1,
    output logic [W_IN-1:0]  mac_x2,
    output logic [W_IN-1:0]  mac_x3,
    output logic [C_IN-1:0]  mac_c0,
    output logic [C_IN-1:0]  mac_c1,
    output logic [C_IN-1:0]  mac_c2,
    output logic [C_IN-1:0]  mac_c3,
    input  logic [Y_OUT-1:0] mac_y,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Y_OUT-1:0] m_data,
    output logic [2:0]       m_phase,
    output logic             busy
);
    logic [HIST-1:0][W_IN-1:0]        hist;
    logic [PHASES-1:0][W_IN-1:0]      frm;
    logic [PHASES+HIST-1:0][W_IN-1:0] xall;
    logic [TAPS-1:0][C_IN-1:0]        coef_sh, coef_act;
    logic [TAPS-1:0][W_IN-1:0]        win, last_win;

    state_t           state, state_nx;
    logic [2:0]       fill_cnt;
    phase_t           phase, infl_phase;
    logic             inflight, accept, issue, pop;
    logic [1:0]       fifo_cnt;
    logic [Y_OUT+2:0] fifo_dout;

    // Index 0 is the oldest history sample, so phase p reads xall[p..p+3].
    assign xall = {frm, hist};
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        accept   = 1'b0;
        issue    = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid && fill_cnt == 3'(PHASES-1))
                    state_nx = RUN;
            end
            RUN: begin
                // Buffer slots plus the result in flight never exceed two.
                issue = (({1'b0, fifo_cnt} + {2'b0, inflight}) < 3'd2) || pop;
                if (issue && phase == phase_t'(PHASES-1))
                    state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        assign win[i] = issue ? xall[{1'b0, phase} + 4'(i)] : last_win[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist       <= '0;
            frm        <= '0;
            coef_sh    <= '0;
            coef_act   <= '0;
            last_win   <= '0;
            fill_cnt   <= 3'd0;
            phase      <= '0;
            infl_phase <= '0;
            inflight   <= 1'b0;
        end else begin
            if (cfg_we)
                coef_sh[cfg_addr] <= cfg_data;
            inflight <= issue;
            if (accept) begin
                frm[fill_cnt] <= s_data;
                if (fill_cnt == 3'(PHASES-1)) begin
                    fill_cnt <= 3'd0;
                    coef_act <= coef_sh;
                    phase    <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
            end
            if (issue) begin
                infl_phase <= phase;
                last_win   <= win;
                if (phase == phase_t'(PHASES-1)) begin
                    phase    <= '0;
                    hist     <= frm[PHASES-1:PHASES-HIST];
                    fill_cnt <= 3'd0;
                end else begin
                    phase <= phase + phase_t'(1);
                end
            end
        end
    end

    fir_out_fifo #(.DW(Y_OUT + 3)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({mac_y, infl_phase}),
        .pop   (pop),
        .valid (m_valid),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign m_data  = fifo_dout[Y_OUT+2:3];
    assign m_phase = fifo_dout[2:0];
    assign busy    = (state == RUN) || inflight || (fifo_cnt != 2'd0);

    assign mac_x0 = win[0];
    assign mac_x1 = win[1];
    assign mac_x2 = win[2];
    assign mac_x3 = win[3];
    assign mac_c0 = coef_act[0];
    assign mac_c1 = coef_act[1];
    assign mac_c2 = coef_act[2];
    assign mac_c3 = coef_act[3];
endmodule

// File: tb/tb_fir_phase_sched.sv
// Directed bench: external MAC beside the scheduler, frame-level output model.
module tb_fir_phase_sched;
    localparam int W_IN = 7, C_IN = 5, Y_OUT = 20;

    logic clk = 1'b0;
    logic rst, s_valid, s_ready, cfg_we, m_valid, m_ready, busy;
    logic [W_IN-1:0]  s_data, mac_x0, mac_x1, mac_x2, mac_x3;
    logic [1:0]       cfg_addr;
    logic [C_IN-1:0]  cfg_data, mac_c0, mac_c1, mac_c2, mac_c3;
    logic [Y_OUT-1:0] mac_y, m_data;
    logic [2:0]       m_phase;

    always #5 clk = ~clk;

    fir_phase_sched #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(Y_OUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mac_x0(mac_x0), .mac_x1(mac_x1), .mac_x2(mac_x2), .mac_x3(mac_x3),
        .mac_c0(mac_c0), .mac_c1(mac_c1), .mac_c2(mac_c2), .mac_c3(mac_c3),
        .mac_y(mac_y), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_phase(m_phase), .busy(busy)
    );

    // External registered MAC unit.
    always @(posedge clk)
        mac_y <= $signed(mac_x0) * $signed(mac_c0) + $signed(mac_x1) * $signed(mac_c1)
               + $signed(mac_x2) * $signed(mac_c2) + $signed(mac_x3) * $signed(mac_c3);

    int checks = 0, errors = 0;
    int exp_d[$], exp_p[$], got_d[$], xs[$];
    int fc[0:3][0:3];
    logic rdy_toggle = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // y[n] = sum c_i * x[n-3+i], frame k = n/6 uses its own coefficient set.
    task automatic build_model(input int nsamp);
        for (int n = 0; n < nsamp; n++) begin
            int y = 0;
            for (int i = 0; i < 4; i++) begin
                int j = n - 3 + i;
                if (j >= 0) y += fc[n / 6][i] * xs[j];
            end
            exp_d.push_back(y);
            exp_p.push_back(n % 6);
        end
    endtask

    task automatic send(input int d);
        int t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 7'(d);
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("s_ready_timeout", int'(t < 300), 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send(xs[i]);
    endtask

    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 5'(d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        cfg_write(0, c0); cfg_write(1, c1); cfg_write(2, c2); cfg_write(3, c3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_d.delete(); exp_p.delete(); got_d.delete(); xs.delete();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_d.size() != 0 || busy) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", int'(t < 600), 1);
        chk("leftover_expected", exp_d.size(), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic impulse_xs();
        xs.delete();
        xs.push_back(1);
        for (int i = 0; i < 11; i++) xs.push_back(0);
    endtask

    task automatic set_fc(input int f, input int c0, input int c1, input int c2, input int c3);
        fc[f][0] = c0; fc[f][1] = c1; fc[f][2] = c2; fc[f][3] = c3;
    endtask

    initial begin
        int cyc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            m_ready = rdy_toggle ? (cyc % 4 == 0) : 1'b1;
        end
    end

    // Compare process: every handshake against the model, stall stability, buffer depth.
    initial begin
        logic pv;
        logic [Y_OUT-1:0] pd;
        logic [2:0] pp;
        pv = 1'b0; pd = '0; pp = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("fifo_count_le2", int'(dut.u_fifo.count <= 2'd2), 1);
                if (pv) begin
                    chk("stall_valid", int'(m_valid), 1);
                    chk("stall_data", int'(m_data), int'(pd));
                    chk("stall_phase", int'(m_phase), int'(pp));
                end
                if (m_valid && m_ready) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_output", int'($signed(m_data)), 99999);
                    end else begin
                        chk("m_data", int'($signed(m_data)), exp_d.pop_front());
                        chk("m_phase", int'(m_phase), exp_p.pop_front());
                    end
                    got_d.push_back(int'($signed(m_data)));
                end
                pv = m_valid && !m_ready;
                pd = m_data;
                pp = m_phase;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mac_x", int'({mac_x0, mac_x1, mac_x2, mac_x3}), 0);
        chk("rst_mac_c", int'({mac_c0, mac_c1, mac_c2, mac_c3}), 0);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Impulse with latency check on the first frame.
        do_reset();
        set_coefs(1, 2, 3, 4);
        set_fc(0, 1, 2, 3, 4); set_fc(1, 1, 2, 3, 4);
        impulse_xs();
        build_model(12);
        send_range(0, 6);
        @(negedge clk); chk("lat_c0_valid", int'(m_valid), 0);
        @(negedge clk); chk("lat_c1_valid", int'(m_valid), 0);
        @(negedge clk); chk("lat_c2_valid", int'(m_valid), 1);
        send_range(6, 12);
        drain();
        chk("imp_y0", got_d[0], 4); chk("imp_y1", got_d[1], 3);
        chk("imp_y2", got_d[2], 2); chk("imp_y3", got_d[3], 1);
        chk("imp_y11", got_d[11], 0);
        chk("imp_idle_ready", int'(s_ready), 1);

        // History across frames.
        do_reset();
        set_coefs(1, 1, 1, 1);
        set_fc(0, 1, 1, 1, 1); set_fc(1, 1, 1, 1, 1);
        for (int i = 1; i <= 12; i++) xs.push_back(i);
        build_model(12);
        send_range(0, 12);
        drain();
        chk("hist_y0", got_d[0], 1); chk("hist_y1", got_d[1], 3); chk("hist_y2", got_d[2], 6);
        chk("hist_y5", got_d[5], 18); chk("hist_y6", got_d[6], 22);
        chk("hist_y7", got_d[7], 26); chk("hist_y8", got_d[8], 30);

        // Backpressure.
        do_reset();
        set_coefs(1, 2, 3, 4);
        set_fc(0, 1, 2, 3, 4); set_fc(1, 1, 2, 3, 4);
        impulse_xs();
        build_model(12);
        rdy_toggle = 1'b1;
        send_range(0, 12);
        drain();
        rdy_toggle = 1'b0;
        chk("bp_count", got_d.size(), 12);
        chk("bp_y0", got_d[0], 4); chk("bp_y3", got_d[3], 1);

        // Coefficient switch between frames.
        do_reset();
        set_fc(0, 0, 0, 0, 2); set_fc(1, 0, 0, 0, 5);
        for (int i = 0; i < 12; i++) xs.push_back(1);
        build_model(12);
        send_range(0, 2);
        set_coefs(0, 0, 0, 2);
        send_range(2, 6);
        set_coefs(0, 0, 0, 5);
        send_range(6, 12);
        drain();
        chk("csw_y0", got_d[0], 2); chk("csw_y5", got_d[5], 2);
        chk("csw_y6", got_d[6], 5); chk("csw_y11", got_d[11], 5);

        // Signed extremes.
        do_reset();
        set_coefs(-16, -16, -16, -16);
        set_fc(0, -16, -16, -16, -16); set_fc(1, -16, -16, -16, -16);
        for (int i = 0; i < 12; i++) xs.push_back(-64);
        build_model(12);
        send_range(0, 12);
        drain();
        chk("sx_y0", got_d[0], 1024); chk("sx_y1", got_d[1], 2048);
        chk("sx_y2", got_d[2], 3072); chk("sx_y3", got_d[3], 4096);
        chk("sx_y11", got_d[11], 4096);

        // Reset at the phase 3 issue: only phases 0 and 1 reach the consumer.
        do_reset();
        set_coefs(1, 2, 3, 4);
        set_fc(0, 1, 2, 3, 4); set_fc(1, 1, 2, 3, 4);
        impulse_xs();
        build_model(2);
        send_range(0, 6);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("rr_valid_c0", int'(m_valid), 0);
        @(negedge clk); chk("rr_valid_c1", int'(m_valid), 0);
        chk("rr_pre_count", got_d.size(), 2);
        chk("rr_pre_left", exp_d.size(), 0);
        got_d.delete(); exp_d.delete(); exp_p.delete();
        chk("rr_busy", int'(busy), 0);
        set_coefs(1, 2, 3, 4);
        build_model(12);
        send_range(0, 12);
        drain();
        chk("rr_y0", got_d[0], 4); chk("rr_y1", got_d[1], 3);
        chk("rr_y2", got_d[2], 2); chk("rr_y3", got_d[3], 1);
        chk("rr_count", got_d.size(), 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
